// File: rtl/cordic_prescale.sv
// rtl/cordic_prescale.sv - folds one CORDIC operand set into the convergence range
module cordic_prescale #(
    parameter int                       WIDTH   = 16,
    parameter logic signed [WIDTH-1:0]  PI      = 16'sd804,
    parameter logic signed [WIDTH-1:0]  HALF_PI = 16'sd402,
    parameter logic signed [WIDTH-1:0]  TWO_PI  = 16'sd1608
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode_in,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    mode,
    output logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y,
    output logic signed [WIDTH-1:0] z,
    output logic                    negate
);

    typedef enum logic [1:0] {IDLE, REDUCE, OUT} state_t;

    state_t state;

    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

    // The most negative value has no positive counterpart, so clamp it.
    function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] v);
        if (v == MOST_NEG)
            return MOST_POS;
        else
            return -v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mode      <= 1'b0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            negate    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode     <= mode_in;
                        x        <= x_in;
                        y        <= y_in;
                        z        <= z_in;
                        negate   <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (mode) begin
                        // Mirror into the right half-plane; the angle offset follows the old y sign.
                        if (x[WIDTH-1]) begin
                            x <= sat_neg(x);
                            y <= sat_neg(y);
                            z <= y[WIDTH-1] ? z - PI : z + PI;
                        end
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (z >= PI) begin
                        z <= z - TWO_PI;
                    end else if (z < -PI) begin
                        z <= z + TWO_PI;
                    end else begin
                        if (z > HALF_PI) begin
                            z      <= z - PI;
                            negate <= 1'b1;
                        end else if (z < -HALF_PI) begin
                            z      <= z + PI;
                            negate <= 1'b1;
                        end else begin
                            negate <= 1'b0;
                        end
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cordic_prescale.md
Name: cordic_prescale

Overview:
- Upstream stage of `cordic`. It accepts one operand set (mode, x, y, z) per transaction and folds it into the CORDIC convergence range.
- Outputs drive `cordic` inputs directly.
- A `negate` tag travels with each result so the downstream post-stage can undo the fold on res1/res2.
- Data format: signed Q8.8, 16 bits. Angles are in radians.

Parameters:
- WIDTH, 16, data width of x/y/z.
- PI, 16'sd804, π in Q8.8.
- HALF_PI, 16'sd402, π/2 in Q8.8.
- TWO_PI, 16'sd1608, 2π in Q8.8.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept an operand set.
- mode_in  in  1  0 = rotation, 1 = vectoring.
- x_in  in  WIDTH  signed Q8.8.
- y_in  in  WIDTH  signed Q8.8.
- z_in  in  WIDTH  signed Q8.8 angle.
- out_valid  out  1  folded operands valid.
- out_ready  in  1  downstream accepts.
- mode  out  1  to cordic.
- x  out  WIDTH  to cordic.
- y  out  WIDTH  to cordic.
- z  out  WIDTH  to cordic.
- negate  out  1  downstream must negate res1/res2.

Behaviour:
- Reset:
  - reset=1 at a rising edge → state IDLE.
  - Outputs after reset: out_valid=0, in_ready=1, mode=0, x=y=z=0, negate=0.
  - Reset overrides everything, including mid-REDUCE and held OUT; any partial transaction is discarded.
- State IDLE:
  - in_ready=1.
  - On in_valid=1: capture mode_in/x_in/y_in/z_in into the output registers, clear negate, go to REDUCE.
- State REDUCE (in_ready=0, out_valid=0). Evaluated once per cycle, in this priority order:
  - Vectoring (mode=1):
    - If x<0: x←−x, y←−y, and z←z+PI if y≥0 (original y), else z←z−PI.
    - z arithmetic wraps mod 2^16.
    - Negating −32768 saturates to +32767.
    - negate stays 0.
    - If x≥0: operands are unchanged.
    - Go to OUT in all vectoring cases. Exactly one REDUCE cycle.
  - Rotation (mode=0):
    - If z≥PI: z←z−TWO_PI, stay in REDUCE.
    - Else if z<−PI: z←z+TWO_PI, stay in REDUCE.
    - Else fold and go to OUT:
      - z>HALF_PI → z←z−PI, negate←1.
      - z<−HALF_PI → z←z+PI, negate←1.
      - otherwise unchanged, negate←0.
    - x and y pass through unchanged in rotation mode.
    - No overflow is possible: each correction moves z toward zero.
- State OUT:
  - out_valid=1, in_ready=0.
  - mode/x/y/z/negate are held stable while out_ready=0.
  - On out_ready=1 → IDLE; out_valid deasserts at the same edge.
  - A new input can be accepted no earlier than the following cycle (no bypass; max throughput is one transaction per k+3 cycles).
- Latency:
  - Accept at edge N; out_valid=1 after edge N+k+1, where k = number of 2π corrections.
  - Rotation: k ≤ 20 for the full Q8.8 range. Vectoring: k=0.
- in_valid is ignored outside IDLE. The upstream source must hold the operands until it sees in_ready.

Test Plan:
- Reset, then x=0x1A60 (26.375), y=0x0E00, z=0x0200 (2.0), mode=0 → one cycle later: x=0x1A60, y=0x0E00, z=0xFEDC (−292), negate=1, out_valid=1.
- Rotation z=0x0A00 (10.0) → two 2π corrections (952, then −656), then fold → z=0x0094 (148), negate=1, out_valid 3 edges after accept. Also z=0x0100 → unchanged, negate=0, latency 1.
- Extremes: z=0x8000 → k=20, z=0x00C4 (196), negate=1. z=0x7FFF → k=20, z=0xFF3B (−197), negate=1.
- Vectoring x=0xE5A0, y=0x0E00, z=0 → x=0x1A60, y=0xF200, z=0x0324, negate=0. Also x=0x8000, y=0xFF00, z=0 → x=0x7FFF, y=0x0100, z=0xFCDC.
- Backpressure: hold out_ready=0 for 5 cycles in OUT → outputs stable, in_ready=0, a new in_valid is not accepted. Release → IDLE; next operand accepted the cycle after.
- Assert reset during REDUCE of z=0x8000 → next edge out_valid=0, in_ready=1, x=y=z=0, negate=0. No stale output appears afterwards.
